// File: rtl/spi_slave_chip_if.sv
// spi_slave_chip_if: SPI mode-0 chip-side responder, oversampled in the CLK domain, MSB first.
// Optional SPI_SLV_ECHO_EN: with no tx word queued, reply with the last received word instead of IDLE_WORD.
module spi_slave_chip_if #(
    parameter int WORD_W = 32,
    parameter int SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_ovf,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(WORD_W);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_s, cs_s, mosi_s, sck_q, cs_q, rise_f, mosi_q, reload_pend;
    logic rise_c, fall_c, cs_fall, word_end, reload_now, load_now;
    logic [WORD_W-2:0] shift_rx;
    logic [WORD_W-1:0] shift_tx, rx_next, fill_word, load_word;
    logic [CW-1:0] bit_cnt;
`ifdef SPI_SLV_ECHO_EN
    logic have_rx;
`endif
    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign busy = ~cs_s;
    always_comb begin
        rise_c = sck_s & ~sck_q;
        fall_c = ~sck_s & sck_q;
        cs_fall = ~cs_s & cs_q;
        rx_next = {shift_rx, mosi_q};
        word_end = (state_q == SHIFT) & rise_f & (bit_cnt == CW'(WORD_W - 1));
        reload_now = (state_q == SHIFT) & ~cs_s & fall_c & reload_pend;
        load_now = (state_q == LOAD) | reload_now;
`ifdef SPI_SLV_ECHO_EN
        fill_word = have_rx ? rx_data : IDLE_WORD;
`else
        fill_word = IDLE_WORD;
`endif
        load_word = tx_valid ? tx_data : fill_word;
        tx_ready = load_now & tx_valid;
        state_d = (state_q == IDLE) ? (cs_fall ? LOAD : IDLE) :
                  (state_q == LOAD) ? SHIFT : (cs_s ? IDLE : SHIFT);
    end
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sck_sync <= '0;
            cs_sync <= '1;
            mosi_sync <= '0;
            sck_q <= 1'b0;
            cs_q <= 1'b1;
            rise_f <= 1'b0;
            mosi_q <= 1'b0;
            state_q <= IDLE;
            bit_cnt <= '0;
            reload_pend <= 1'b0;
            shift_rx <= '0;
            shift_tx <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            rx_ovf <= 1'b0;
            frame_err <= 1'b0;
            spi_miso <= 1'b0;
`ifdef SPI_SLV_ECHO_EN
            have_rx <= 1'b0;
`endif
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_q <= sck_s;
            cs_q <= cs_s;
            // a rise seen alongside the cs fall waits out LOAD before it is consumed
            rise_f <= rise_c | (rise_f & (state_q == LOAD));
            if (rise_c) mosi_q <= mosi_s;
            state_q <= state_d;
            rx_valid <= word_end;
            rx_ovf <= rx_ovf | (rx_valid & ~rx_ready);
            frame_err <= (state_q == SHIFT) & cs_s & (bit_cnt != '0);
            reload_pend <= (state_q == SHIFT) & ~cs_s & (word_end | (reload_pend & ~fall_c));
            if (state_q == SHIFT && rise_f) begin
                shift_rx <= rx_next[WORD_W-2:0];
                bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
            end
            if (word_end) rx_data <= rx_next;
            if (load_now) begin
                shift_tx <= load_word;
                spi_miso <= load_word[WORD_W-1];
            end else if (state_q == SHIFT && fall_c) begin
                shift_tx <= shift_tx << 1;
                spi_miso <= shift_tx[WORD_W-2];
            end
            if (state_q == SHIFT && cs_s) bit_cnt <= '0;
            if (state_q == IDLE || (state_q == SHIFT && cs_s)) spi_miso <= 1'b0;
`ifdef SPI_SLV_ECHO_EN
            have_rx <= have_rx | word_end;
`endif
        end
    end
endmodule

// File: tb/tb_spi_slave_chip_if.sv
// tb_spi_slave_chip_if: randomized SPI master against a word-level model of the responder.
module tb_spi_slave_chip_if;
`ifdef SPI_SLV_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    logic CLK = 0, rst_n = 0, spi_sck = 0, spi_cs = 1, spi_mosi = 0;
    logic rx_ready = 1, tx_valid = 0;
    logic [31:0] tx_data = 0;
    logic spi_miso, rx_valid, tx_ready, rx_ovf, frame_err, busy;
    logic [31:0] rx_data;
    int n_cmp = 0, n_bad = 0, n_txr = 0, n_fe = 0, t0 = 0, fe_base = 0, words = 0;
    logic [31:0] mw[16], tw[16], cap[16];
    bit tv[16];
    logic [31:0] exp_rx[$];
    logic [31:0] last_rx = 0;
    bit have_rx = 0, ovf_m = 0;

    always #5 CLK = ~CLK;

    spi_slave_chip_if dut (
        .CLK(CLK), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_ovf(rx_ovf),
        .frame_err(frame_err), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    function automatic logic [31:0] fill_m();
        return (ECHO && have_rx) ? last_rx : 32'h0;
    endfunction

    always @(negedge CLK) begin
        if (rx_valid) begin
            if (exp_rx.size() == 0) chk("rx_valid_spurious", rx_valid, 1'b0);
            else chk("rx_data", rx_data, exp_rx.pop_front());
        end
        n_txr += tx_ready;
        n_fe += frame_err;
    end

    task automatic do_reset(input int n);
        rst_n = 0;
        clks(1);
        spi_cs = 1;
        spi_sck = 0;
        clks(n - 1);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_flags", {26'd0, spi_miso, rx_valid, tx_ready, rx_ovf, frame_err, busy}, 32'h0);
        rst_n = 1;
        ovf_m = 0;
        have_rx = 0;
        last_rx = 0;
        exp_rx.delete();
        clks(4);
    endtask

    task automatic spi_frame(input int nw, input int half, input int cut, input bit lead);
        int total, done, fe0, tr0, exp_tr, sent;
        logic [31:0] w;
        total = (cut > 0) ? cut : nw * 32;
        done = total / 32;
        for (int k = 0; k < done; k++) exp_rx.push_back(mw[k]);
        fe0 = n_fe;
        tr0 = n_txr;
        sent = 0;
        tx_valid = tv[0];
        tx_data = tw[0];
        if (!lead) begin
            spi_cs = 0;
            clks(2 * half);
        end
        for (int k = 0; k < nw; k++)
            for (int b = 31; b >= 0; b--)
                if (sent < total) begin
                    spi_mosi = mw[k][b];
                    if (sent > 0 || !lead) clks(half);
                    spi_cs = 0;
                    cap[k][b] = spi_miso;
                    spi_sck = 1;
                    if (b == 31) begin
                        tx_valid = (k + 1 < nw) ? tv[k+1] : 1'b0;
                        tx_data = tw[k+1];
                    end
                    clks(half);
                    spi_sck = 0;
                    sent++;
                end
        clks(half);
        spi_cs = 1;
        clks(12);
        tx_valid = 0;
        exp_tr = 0;
        for (int k = 0; k < nw && k <= done; k++) exp_tr += int'(tv[k]);
        chk("frame_err_pulses", n_fe - fe0, (total % 32 != 0) ? 1 : 0);
        chk("tx_ready_pulses", n_txr - tr0, exp_tr);
        for (int k = 0; k < done; k++) begin
            w = tv[k] ? tw[k] : fill_m();
            if (half >= 4) chk("miso_word", cap[k], w);
            have_rx = 1;
            last_rx = mw[k];
        end
        if (done > 0 && !rx_ready) ovf_m = 1;
        chk("rx_pending", exp_rx.size(), 0);
        chk("rx_ovf", rx_ovf, ovf_m);
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        tx_valid = 1;
        tx_data = 32'hDEADBEEF;
        do_reset(4);
        tx_valid = 0;
        // reset in the middle of a word: silent abort, then a clean frame
        spi_cs = 0;
        clks(8);
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom);
            clks(4);
            spi_sck = 1;
            clks(4);
            spi_sck = 0;
        end
        fe_base = n_fe;
        do_reset(3);
        chk("rst_no_frame_err", n_fe - fe_base, 0);
        mw[0] = 32'h0F1E2D3C; tv[0] = 1; tw[0] = 32'h55AA33CC;
        spi_frame(1, 4, 0, 0);
        // single word with literal expectations
        mw[0] = 32'h12345678; tv[0] = 1; tw[0] = 32'hA5A50F0F;
        t0 = n_txr;
        spi_frame(1, 4, 0, 0);
        chk("t2_rx_data", rx_data, 32'h12345678);
        chk("t2_miso", cap[0], 32'hA5A50F0F);
        chk("t2_tx_ready", n_txr - t0, 1);
        // burst with a gap in the tx stream
        mw[0] = 32'hCAFE0001; mw[1] = 32'h0BADF00D; mw[2] = 32'h600DD00D;
        tv[0] = 1; tv[1] = 0; tv[2] = 1;
        tw[0] = 32'h11112222; tw[1] = 32'h99999999; tw[2] = 32'h33334444; tw[3] = 32'h77777777;
        spi_frame(3, 4, 0, 0);
        chk("t3_miso0", cap[0], 32'h11112222);
        chk("t3_miso1", cap[1], ECHO ? 32'hCAFE0001 : 32'h0);
        chk("t3_miso2", cap[2], 32'h33334444);
        chk("t3_rx_last", rx_data, 32'h600DD00D);
        // abort after 13 bits, then an intact word
        mw[0] = 32'hFFFF0000; tv[0] = 0;
        spi_frame(1, 4, 13, 0);
        mw[0] = 32'h87654321;
        spi_frame(1, 4, 0, 0);
        chk("t4_rx", rx_data, 32'h87654321);
        // overflow is sticky until reset
        rx_ready = 0;
        mw[0] = 32'h13579BDF;
        spi_frame(1, 4, 0, 0);
        chk("t5_ovf", rx_ovf, 1'b1);
        rx_ready = 1;
        spi_frame(2, 4, 0, 0);
        spi_frame(1, 4, 0, 0);
        chk("t5_ovf_hold", rx_ovf, 1'b1);
        do_reset(3);
        // random frames at CLK/8 with MISO checked, some aborted
        for (int f = 0; f < 15; f++) begin
            int nw, cut;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < 16; k++) begin
                mw[k] = $urandom();
                tw[k] = $urandom();
                tv[k] = 1'($urandom_range(0, 1));
            end
            cut = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nw * 32 - 1) : 0;
            rx_ready = ($urandom_range(0, 7) != 0);
            spi_frame(nw, 4, cut, 0);
        end
        // random frames at CLK/4, some with cs fall on the first sck rise
        for (int k = 0; k < 16; k++) tv[k] = 0;
        words = 0;
        while (words < 300) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) mw[k] = $urandom();
            rx_ready = ($urandom_range(0, 9) != 0);
            spi_frame(nw, 2, 0, 1'($urandom_range(0, 1)));
            words += nw;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
